// File: rtl/usb_endpi_sched.sv
// IN-endpoint load scheduler: round-robin between two byte-stream requesters,
// packetizes each stream into MAX_PKT-byte packets written to ENDPIx_DATA,
// then arms the endpoint through ENDPIx_CONTROL over the shared I/O bus.
module usb_endpi_sched #(
    parameter int unsigned MAX_PKT       = 8,
    parameter logic [11:0] ADDR_EP0_CTRL = 12'h100,
    parameter logic [11:0] ADDR_EP1_CTRL = 12'h102,
    parameter logic [11:0] ADDR_EP0_DATA = 12'h104,
    parameter logic [11:0] ADDR_EP1_DATA = 12'h106
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        usb_reset,
    input  logic        src0_valid,
    input  logic [7:0]  src0_data,
    input  logic        src0_last,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [7:0]  src1_data,
    input  logic        src1_last,
    output logic        src1_ready,
    input  logic [1:0]  ep_busy,
    input  logic [1:0]  ep_full,
    output logic        io_req,
    input  logic        io_gnt,
    output logic [11:0] io_addr,
    output logic [15:0] io_dout,
    output logic [1:0]  pkt_armed,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_LOAD, S_ARM, S_WAIT} state_t;

    state_t     state_q;
    logic       sel_q;       // endpoint being served
    logic       rr_q;        // last endpoint served
    logic [3:0] cnt_q;       // bytes loaded into the current packet
    logic [1:0] zlp_pend_q;  // a zero-length packet is owed to this endpoint
    logic       zlp_q;       // current packet is the owed zero-length packet

    logic       sv_valid;
    logic [7:0] sv_data;
    logic       sv_last;
    logic       full_sel;
    logic [1:0] elig;
    logic       ld_ready;
    logic       accept;
    logic [4:0] cnt_nxt;
    logic       pkt_full;

    assign sv_valid = sel_q ? src1_valid : src0_valid;
    assign sv_data  = sel_q ? src1_data  : src0_data;
    assign sv_last  = sel_q ? src1_last  : src0_last;
    assign full_sel = ep_full[sel_q];
    assign elig     = ~ep_busy & ({src1_valid, src0_valid} | zlp_pend_q);
    // usb_reset gates every handshake in the same cycle it is seen
    assign ld_ready = (state_q == S_LOAD) && !usb_reset && io_gnt && !full_sel;
    assign accept   = ld_ready && sv_valid;
    assign cnt_nxt  = {1'b0, cnt_q} + 5'd1;
    assign pkt_full = (cnt_nxt == 5'(MAX_PKT));
    assign busy     = (state_q != S_IDLE);

    // bus request, address/data and handshake outputs decoded from the state
    always_comb begin
        io_req     = 1'b0;
        io_addr    = 12'h000;
        io_dout    = 16'h0000;
        src0_ready = 1'b0;
        src1_ready = 1'b0;
        pkt_armed  = 2'b00;
        if (!usb_reset) begin
            case (state_q)
                S_LOAD: begin
                    src0_ready = ld_ready && !sel_q;
                    src1_ready = ld_ready && sel_q;
                    if (sv_valid && !full_sel) begin
                        io_req  = 1'b1;
                        io_addr = sel_q ? ADDR_EP1_DATA : ADDR_EP0_DATA;
                        io_dout = {8'h00, sv_data};
                    end
                end
                S_ARM: begin
                    io_req  = 1'b1;
                    io_addr = sel_q ? ADDR_EP1_CTRL : ADDR_EP0_CTRL;
                    io_dout = 16'h0002;  // ack=1, stall=0
                    pkt_armed[sel_q] = io_gnt;
                end
                default: ;
            endcase
        end
    end

    // scheduler state machine
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            rr_q       <= 1'b1;
            cnt_q      <= 4'd0;
            zlp_pend_q <= 2'b00;
            zlp_q      <= 1'b0;
        end else if (usb_reset) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b1;
            cnt_q      <= 4'd0;
            zlp_pend_q <= 2'b00;
            zlp_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|elig) begin
                        // contention goes to the endpoint not served last
                        sel_q   <= (&elig) ? ~rr_q : elig[1];
                        state_q <= S_SEL;
                    end
                end
                S_SEL: begin
                    cnt_q   <= 4'd0;
                    zlp_q   <= zlp_pend_q[sel_q];
                    state_q <= zlp_pend_q[sel_q] ? S_ARM : S_LOAD;
                end
                S_LOAD: begin
                    if (accept) begin
                        cnt_q <= cnt_nxt[3:0];
                        if (sv_last || pkt_full) state_q <= S_ARM;
                        // a transfer ending exactly on a full packet needs a ZLP
                        if (sv_last && pkt_full) zlp_pend_q[sel_q] <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (io_gnt) begin
                        if (zlp_q) zlp_pend_q[sel_q] <= 1'b0;
                        rr_q    <= sel_q;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // hold until the SIE shows the ack so we never re-arm early
                    if (ep_busy[sel_q]) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_endpi_sched.sv
// Bench for usb_endpi_sched: bus monitor, SIE busy-flag model, packetizer
// reference model, table-driven transfers, hand sequences and random traffic.
module tb_usb_endpi_sched;

    localparam int MAXP = 8;
    localparam logic [11:0] A_C0 = 12'h100;
    localparam logic [11:0] A_C1 = 12'h102;
    localparam logic [11:0] A_D0 = 12'h104;
    localparam logic [11:0] A_D1 = 12'h106;

    logic        clk = 1'b0;
    logic        reset_n, usb_reset;
    logic        src0_valid, src0_last, src0_ready;
    logic        src1_valid, src1_last, src1_ready;
    logic [7:0]  src0_data, src1_data;
    logic [1:0]  ep_busy, ep_full, pkt_armed;
    logic        io_req, io_gnt, busy;
    logic [11:0] io_addr;
    logic [15:0] io_dout;

    usb_endpi_sched #(
        .MAX_PKT(MAXP), .ADDR_EP0_CTRL(A_C0), .ADDR_EP1_CTRL(A_C1),
        .ADDR_EP0_DATA(A_D0), .ADDR_EP1_DATA(A_D1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .usb_reset(usb_reset),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_last(src0_last), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_last(src1_last), .src1_ready(src1_ready),
        .ep_busy(ep_busy), .ep_full(ep_full), .io_req(io_req), .io_gnt(io_gnt),
        .io_addr(io_addr), .io_dout(io_dout), .pkt_armed(pkt_armed), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic l; } sb_t;
    typedef struct { int c; logic [11:0] a; logic [15:0] d; } wl_t;
    typedef struct { int ep; int len; int n; int sz0; int sz1; int sz2; } vec_t;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int unsigned gnt_pct = 100, valid_pct = 100, full_pct = 0;
    int arm_lag = 0, busy_dly = 3;
    bit rand_sie = 0;
    logic [1:0] full_force = 2'b00;
    bit acc0 = 0, acc1 = 0;
    int bfrom [2] = '{0, 0};
    int bto   [2] = '{0, 0};
    bit busy_log [0:65535];

    sb_t        srcq      [2][$];
    logic [7:0] pend      [2][$];
    logic [7:0] obs_bytes [2][$];
    logic [7:0] exp_bytes [2][$];
    int         obs_sizes [2][$];
    int         exp_sizes [2][$];
    wl_t        wlog[$];
    int         arm_ep[$];
    int         arm_c[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference packetizer: full MAXP chunks, then the remainder, and a
    // zero-length packet when the transfer ends exactly on a packet boundary.
    task automatic add_transfer(input int ep, input int len, input logic [7:0] base, input bit model);
        int rem;
        for (int i = 0; i < len; i++) begin
            srcq[ep].push_back({8'(base + 8'(i)), (i == len - 1)});
            if (model) exp_bytes[ep].push_back(8'(base + 8'(i)));
        end
        if (model) begin
            rem = len;
            while (rem > MAXP) begin exp_sizes[ep].push_back(MAXP); rem -= MAXP; end
            exp_sizes[ep].push_back(rem);
            if (rem == MAXP) exp_sizes[ep].push_back(0);
        end
    endtask

    // observe the bus at mid-cycle
    task automatic monitor();
        logic hs0, hs1, wr;
        int ep, lag, dly;
        wl_t e;
        hs0 = src0_valid && src0_ready;
        hs1 = src1_valid && src1_ready;
        wr  = io_req && io_gnt;
        acc0 = hs0; acc1 = hs1;
        if (cyc < 65536) busy_log[cyc] = busy;
        if (!io_req) chk("idle_bus_zero", 32'({io_addr, io_dout}), 32'd0);
        chk("one_ready", 32'(src0_ready & src1_ready), 32'd0);
        if (usb_reset) begin pend[0].delete(); pend[1].delete(); end
        if (wr) begin e.c = cyc; e.a = io_addr; e.d = io_dout; wlog.push_back(e); end
        if (wr && io_addr == A_D0) begin
            chk("d0_handshake", 32'(hs0), 32'd1);
            chk("d0_data", 32'(io_dout), 32'({8'h00, src0_data}));
            pend[0].push_back(io_dout[7:0]);
        end else if (wr && io_addr == A_D1) begin
            chk("d1_handshake", 32'(hs1), 32'd1);
            chk("d1_data", 32'(io_dout), 32'({8'h00, src1_data}));
            pend[1].push_back(io_dout[7:0]);
        end else begin
            chk("handshake_without_write", 32'(hs0 | hs1), 32'd0);
        end
        if (wr && (io_addr == A_C0 || io_addr == A_C1)) begin
            ep = (io_addr == A_C1) ? 1 : 0;
            chk("ctrl_data", 32'(io_dout), 32'h0002);
            chk("arm_pulse", 32'(pkt_armed), (ep == 1) ? 32'd2 : 32'd1);
            obs_sizes[ep].push_back(pend[ep].size());
            foreach (pend[ep][i]) obs_bytes[ep].push_back(pend[ep][i]);
            pend[ep].delete();
            arm_c.push_back(cyc); arm_ep.push_back(ep);
            lag = rand_sie ? int'($urandom_range(2)) : arm_lag;
            dly = rand_sie ? int'($urandom_range(6, 1)) : busy_dly;
            bfrom[ep] = cyc + 1 + lag;
            bto[ep]   = bfrom[ep] + dly;
        end else begin
            chk("no_arm_pulse", 32'(pkt_armed), 32'd0);
        end
    endtask

    // update sources, grant, FIFO-full and SIE busy flags just after the edge
    task automatic drive();
        cyc++;
        if (acc0) void'(srcq[0].pop_front());
        if (acc1) void'(srcq[1].pop_front());
        acc0 = 0; acc1 = 0;
        src0_valid = (srcq[0].size() > 0) && ($urandom_range(99) < valid_pct);
        src1_valid = (srcq[1].size() > 0) && ($urandom_range(99) < valid_pct);
        {src0_data, src0_last} = (srcq[0].size() > 0) ? srcq[0][0] : 9'h0;
        {src1_data, src1_last} = (srcq[1].size() > 0) ? srcq[1][0] : 9'h0;
        io_gnt = ($urandom_range(99) < gnt_pct);
        for (int i = 0; i < 2; i++) begin
            ep_full[i] = full_force[i] || ($urandom_range(99) < full_pct);
            ep_busy[i] = (cyc >= bfrom[i]) && (cyc < bto[i]);
        end
    endtask

    task automatic tick();
        @(negedge clk); monitor();
        @(posedge clk); #1; drive();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (!(srcq[0].size() == 0 && srcq[1].size() == 0 && busy == 1'b0 &&
                 obs_sizes[0].size() >= exp_sizes[0].size() &&
                 obs_sizes[1].size() >= exp_sizes[1].size()) && n < budget) begin
            tick(); n++;
        end
        chk("done_within_budget", 32'(n < budget), 32'd1);
        repeat (25) tick();
    endtask

    task automatic compare_model(input string tag);
        for (int e = 0; e < 2; e++) begin
            int nb = 0;
            chk($sformatf("%s_ep%0d_npkts", tag, e), 32'(obs_sizes[e].size()), 32'(exp_sizes[e].size()));
            for (int i = 0; i < exp_sizes[e].size() && i < obs_sizes[e].size(); i++)
                if (obs_sizes[e][i] != exp_sizes[e][i]) nb++;
            chk($sformatf("%s_ep%0d_sizes", tag, e), 32'(nb), 32'd0);
            chk($sformatf("%s_ep%0d_nbytes", tag, e), 32'(obs_bytes[e].size()), 32'(exp_bytes[e].size()));
            nb = 0;
            for (int i = 0; i < exp_bytes[e].size() && i < obs_bytes[e].size(); i++)
                if (obs_bytes[e][i] !== exp_bytes[e][i]) nb++;
            chk($sformatf("%s_ep%0d_bytes", tag, e), 32'(nb), 32'd0);
            obs_sizes[e].delete(); exp_sizes[e].delete();
            obs_bytes[e].delete(); exp_bytes[e].delete(); pend[e].delete();
        end
        arm_ep.delete(); arm_c.delete(); wlog.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int c0, n;
        int exp_order [6] = '{0, 1, 0, 1, 0, 1};

        tbl[0] = '{0,  3, 1, 3, 0, 0};
        tbl[1] = '{1,  8, 2, 8, 0, 0};
        tbl[2] = '{0,  1, 1, 1, 0, 0};
        tbl[3] = '{1,  9, 2, 8, 1, 0};
        tbl[4] = '{0, 16, 3, 8, 8, 0};
        tbl[5] = '{1, 13, 2, 8, 5, 0};

        // reset with every input active
        reset_n = 1'b0; usb_reset = 1'b1;
        src0_valid = 1'b1; src0_data = 8'hFF; src0_last = 1'b1;
        src1_valid = 1'b1; src1_data = 8'hFF; src1_last = 1'b1;
        ep_busy = 2'b11; ep_full = 2'b11; io_gnt = 1'b1;
        #3;
        chk("rst_ready", 32'({src0_ready, src1_ready}), 32'd0);
        chk("rst_io_req", 32'(io_req), 32'd0);
        chk("rst_io_addr", 32'(io_addr), 32'd0);
        chk("rst_io_dout", 32'(io_dout), 32'd0);
        chk("rst_pkt_armed", 32'(pkt_armed), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        usb_reset = 1'b0; reset_n = 1'b1;
        drive();
        repeat (3) begin
            tick(); #2;
            chk("idle_after_reset", 32'(busy), 32'd0);
        end

        // EP0 three bytes: cycle-exact timing and WAIT holding for the ack flag
        arm_lag = 3; busy_dly = 3;
        wlog.delete();
        add_transfer(0, 3, 8'hA1, 1);
        c0 = cyc + 1;
        while (cyc < c0 + 12) tick();
        chk("t3_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() >= 4) begin
            for (int i = 0; i < 3; i++) begin
                chk("t3_data_cycle", 32'(wlog[i].c - c0), 32'(i + 2));
                chk("t3_data_addr", 32'(wlog[i].a), 32'(A_D0));
                chk("t3_data_val", 32'(wlog[i].d), 32'(16'h00A1 + 16'(i)));
            end
            chk("t3_ctrl_cycle", 32'(wlog[3].c - c0), 32'd5);
            chk("t3_ctrl_addr", 32'(wlog[3].a), 32'(A_C0));
        end
        chk("t3_arm_cycle", (arm_c.size() > 0) ? 32'(arm_c[0] - c0) : 32'hFFFF, 32'd5);
        chk("t3_idle_detect", 32'(busy_log[c0]), 32'd0);
        chk("t3_sel_busy", 32'(busy_log[c0 + 1]), 32'd1);
        for (int i = 6; i <= 9; i++) chk("t3_wait_held", 32'(busy_log[c0 + i]), 32'd1);
        chk("t3_back_to_idle", 32'(busy_log[c0 + 10]), 32'd0);
        run_until_done(200);
        compare_model("t3");
        arm_lag = 0;

        // backpressure: grant withheld, then FIFO full, then resume
        add_transfer(0, 6, 8'h30, 1);
        n = 0;
        while (pend[0].size() < 2 && n < 100) begin tick(); n++; end
        chk("bp_reach_byte2", 32'(pend[0].size()), 32'd2);
        gnt_pct = 0; io_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_stall_req", 32'(io_req), 32'd1);
            chk("bp_stall_addr", 32'(io_addr), 32'(A_D0));
            chk("bp_stall_data", 32'(io_dout), 32'h0032);
            chk("bp_stall_ready", 32'(src0_ready), 32'd0);
            if (i == 4) begin gnt_pct = 100; full_force = 2'b01; end
            tick();
        end
        chk("bp_no_bytes_lost", 32'(pend[0].size()), 32'd2);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("bp_full_req", 32'(io_req), 32'd0);
            chk("bp_full_ready", 32'(src0_ready), 32'd0);
            if (i == 2) full_force = 2'b00;
            tick();
        end
        run_until_done(200);
        compare_model("bp");

        // usb_reset in LOAD after two bytes: remaining 8 bytes form a fresh packet
        add_transfer(1, 10, 8'h50, 0);
        exp_sizes[1].push_back(8); exp_sizes[1].push_back(0);
        for (int i = 2; i < 10; i++) exp_bytes[1].push_back(8'(8'h50 + 8'(i)));
        n = 0;
        while (pend[1].size() < 2 && n < 100) begin tick(); n++; end
        usb_reset = 1'b1; #2;
        chk("ur_req_dropped", 32'(io_req), 32'd0);
        chk("ur_ready_dropped", 32'(src1_ready), 32'd0);
        tick(); usb_reset = 1'b0; #2;
        chk("ur_idle", 32'(busy), 32'd0);
        chk("ur_idle_req", 32'(io_req), 32'd0);
        run_until_done(300);
        compare_model("ur_load");

        // both sources streaming 20 bytes: strict alternation, no ZLP
        busy_dly = 4;
        add_transfer(0, 20, 8'h00, 1);
        add_transfer(1, 20, 8'h80, 1);
        run_until_done(500);
        chk("rr_narms", 32'(arm_ep.size()), 32'd6);
        for (int i = 0; i < 6 && i < arm_ep.size(); i++)
            chk("rr_order", 32'(arm_ep[i]), 32'(exp_order[i]));
        compare_model("rr");
        busy_dly = 3;

        // usb_reset in WAIT after an exact 8-byte transfer discards the owed ZLP
        arm_lag = 4;
        add_transfer(0, 8, 8'h70, 0);
        exp_sizes[0].push_back(8);
        for (int i = 0; i < 8; i++) exp_bytes[0].push_back(8'(8'h70 + 8'(i)));
        n = 0;
        while (obs_sizes[0].size() < 1 && n < 100) begin tick(); n++; end
        usb_reset = 1'b1; #2;
        chk("urw_req_dropped", 32'(io_req), 32'd0);
        tick(); usb_reset = 1'b0;
        run_until_done(300);
        compare_model("ur_wait");
        arm_lag = 0;

        // table of single-endpoint transfers with hand-computed packet sizes
        for (int k = 0; k < 6; k++) begin
            add_transfer(tbl[k].ep, tbl[k].len, 8'(8'h10 * k + 1), 1);
            run_until_done(300);
            chk($sformatf("tbl%0d_npkts", k), 32'(obs_sizes[tbl[k].ep].size()), 32'(tbl[k].n));
            if (obs_sizes[tbl[k].ep].size() > 0)
                chk($sformatf("tbl%0d_sz0", k), 32'(obs_sizes[tbl[k].ep][0]), 32'(tbl[k].sz0));
            if (tbl[k].n > 1 && obs_sizes[tbl[k].ep].size() > 1)
                chk($sformatf("tbl%0d_sz1", k), 32'(obs_sizes[tbl[k].ep][1]), 32'(tbl[k].sz1));
            if (tbl[k].n > 2 && obs_sizes[tbl[k].ep].size() > 2)
                chk($sformatf("tbl%0d_sz2", k), 32'(obs_sizes[tbl[k].ep][2]), 32'(tbl[k].sz2));
            compare_model($sformatf("tbl%0d", k));
        end

        // random traffic against the reference packetizer
        gnt_pct = 60; valid_pct = 70; full_pct = 20; rand_sie = 1;
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < 2; e++) begin
                int nt;
                nt = int'($urandom_range(3, 1));
                for (int t = 0; t < nt; t++) begin
                    int len;
                    len = ($urandom_range(3) == 0) ? 8 * int'($urandom_range(2, 1))
                                                   : int'($urandom_range(20, 1));
                    add_transfer(e, len, 8'($urandom_range(255)), 1);
                end
            end
            run_until_done(6000);
            compare_model($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
